// File: rtl/capture_burst_transfer.sv
// capture_burst_transfer: captures enable-qualified samples into RAM, then unloads them in acknowledged bursts
module capture_burst_transfer #(
  parameter int address_width = 14,
  parameter int max_ram_address = 16384,
  parameter int burst_index = 8,
  parameter int data_width = 16
) (
  input  logic variable_clk_2,
  input  logic reset,
  input  logic start_signal,
  input  logic enable_2,
  input  logic [data_width-1:0] din,
  output logic burst_req,
  input  logic burst_ack,
  output logic [$clog2(burst_index+1)-1:0] burst_len,
  output logic [data_width-1:0] dout,
  output logic dout_valid,
  input  logic dout_ready,
  output logic transfer_done,
  output logic overflow
);
  localparam int lw = $clog2(burst_index + 1);
  localparam int aw = address_width + 1;
  typedef enum logic [2:0] {IDLE, CAPTURE, REQ, BURST, DONE} state_t;
  state_t state_q, state_d;
  logic [aw-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, remaining_q, remaining_d, rem_src;
  logic [lw-1:0] issue_cnt_q, issue_cnt_d, acc_cnt_q, acc_cnt_d, burst_len_q, burst_len_d, next_len;
  logic [data_width-1:0] dout_q, dout_d, skid_q, skid_d, ram_rd_q;
  logic rd_pend_q, rd_pend_d, skid_valid_q, skid_valid_d, dout_valid_q, dout_valid_d;
  logic burst_req_q, burst_req_d, transfer_done_q, transfer_done_d, overflow_q, overflow_d;
  logic wr_en, rd_en, accept, hold, last_acc;
  logic [data_width-1:0] mem [2**address_width];
  assign wr_en = enable_2 && ((state_q == IDLE && !start_signal) ||
                 (state_q == CAPTURE && wr_addr_q < aw'(max_ram_address)));
  assign accept = dout_valid_q && dout_ready;
  assign hold = dout_valid_q && !dout_ready;
  // a read is launched only if the word can still land in the output/skid pair
  assign rd_en = state_q == BURST && issue_cnt_q < burst_len_q &&
                 (2'(dout_valid_q) + 2'(skid_valid_q) + 2'(rd_pend_q) - 2'(accept)) < 2'd2;
  assign last_acc = accept && acc_cnt_q == burst_len_q - lw'(1);
  assign rem_src = state_q == CAPTURE ? wr_addr_q : remaining_q;
  assign next_len = rem_src < aw'(burst_index) ? lw'(rem_src) : lw'(burst_index);
  assign burst_req = burst_req_q;
  assign burst_len = burst_len_q;
  assign dout = dout_q;
  assign dout_valid = dout_valid_q;
  assign transfer_done = transfer_done_q;
  assign overflow = overflow_q;
  // sample RAM: write during capture, synchronous read for unload
  always_ff @(posedge variable_clk_2) begin
    if (wr_en) mem[wr_addr_q[address_width-1:0]] <= din;
    ram_rd_q <= mem[rd_addr_q[address_width-1:0]];
  end
  // next-state: skid buffer datapath plus capture/request/burst sequencing
  always_comb begin
    state_d = state_q;
    wr_addr_d = wr_addr_q;
    remaining_d = remaining_q;
    burst_len_d = burst_len_q;
    burst_req_d = burst_req_q;
    overflow_d = overflow_q;
    transfer_done_d = 1'b0;
    rd_pend_d = rd_en;
    rd_addr_d = rd_addr_q + aw'(rd_en);
    issue_cnt_d = issue_cnt_q + lw'(rd_en);
    acc_cnt_d = acc_cnt_q + lw'(accept);
    dout_valid_d = hold || skid_valid_q || rd_pend_q;
    dout_d = hold ? dout_q : skid_valid_q ? skid_q : rd_pend_q ? ram_rd_q : dout_q;
    skid_valid_d = hold ? (skid_valid_q || rd_pend_q) : (skid_valid_q && rd_pend_q);
    skid_d = rd_pend_q ? ram_rd_q : skid_q;
    case (state_q)
      IDLE: if (!start_signal && enable_2) begin
        wr_addr_d = aw'(1);
        state_d = CAPTURE;
      end
      CAPTURE: if (enable_2) begin
        wr_addr_d = wr_addr_q < aw'(max_ram_address) ? wr_addr_q + aw'(1) : wr_addr_q;
        overflow_d = overflow_q || wr_addr_q == aw'(max_ram_address);
      end else begin
        remaining_d = wr_addr_q;
        burst_req_d = 1'b1;
        burst_len_d = next_len;
        state_d = REQ;
      end
      REQ: if (burst_ack) begin
        burst_req_d = 1'b0;
        remaining_d = remaining_q - aw'(burst_len_q);
        issue_cnt_d = '0;
        acc_cnt_d = '0;
        state_d = BURST;
      end
      BURST: if (last_acc) begin
        transfer_done_d = remaining_q == '0;
        burst_req_d = remaining_q != '0;
        burst_len_d = remaining_q != '0 ? next_len : burst_len_q;
        state_d = remaining_q == '0 ? DONE : REQ;
      end
      default: begin
        wr_addr_d = '0;
        rd_addr_d = '0;
        state_d = IDLE;
      end
    endcase
  end
  // state and registered outputs, synchronous reset aborts everything
  always_ff @(posedge variable_clk_2) begin
    if (reset) begin
      state_q <= IDLE;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      remaining_q <= '0;
      issue_cnt_q <= '0;
      acc_cnt_q <= '0;
      burst_len_q <= '0;
      burst_req_q <= 1'b0;
      dout_q <= '0;
      dout_valid_q <= 1'b0;
      skid_q <= '0;
      skid_valid_q <= 1'b0;
      rd_pend_q <= 1'b0;
      transfer_done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      remaining_q <= remaining_d;
      issue_cnt_q <= issue_cnt_d;
      acc_cnt_q <= acc_cnt_d;
      burst_len_q <= burst_len_d;
      burst_req_q <= burst_req_d;
      dout_q <= dout_d;
      dout_valid_q <= dout_valid_d;
      skid_q <= skid_d;
      skid_valid_q <= skid_valid_d;
      rd_pend_q <= rd_pend_d;
      transfer_done_q <= transfer_done_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_capture_burst_transfer.sv
// tb_capture_burst_transfer: directed checks of capture, burst unload, overflow and abort behaviour
module tb_capture_burst_transfer;
  logic clk, reset, start_signal, enable_2, burst_ack, dout_ready, sel;
  logic [15:0] din;
  logic r1, r2, v1, v2, t1, t2, o1, o2;
  logic [3:0] l1, l2;
  logic [15:0] d1, d2;
  logic burst_req, dout_valid, transfer_done, overflow;
  logic [3:0] burst_len;
  logic [15:0] dout;
  int checks, errors, cyc, last_acc, td_n, td_cyc, req_n, contig, ack_cyc;
  bit prev_hold, prev_req, lat_arm;
  logic [15:0] prev_dout;
  logic [15:0] got[$];
  logic [3:0] lens[$];

  capture_burst_transfer dut (.variable_clk_2(clk), .reset(reset), .start_signal(start_signal),
    .enable_2(enable_2), .din(din), .burst_req(r1), .burst_ack(burst_ack), .burst_len(l1),
    .dout(d1), .dout_valid(v1), .dout_ready(dout_ready), .transfer_done(t1), .overflow(o1));
  capture_burst_transfer #(.max_ram_address(16)) dut_small (.variable_clk_2(clk), .reset(reset),
    .start_signal(start_signal), .enable_2(enable_2), .din(din), .burst_req(r2), .burst_ack(burst_ack),
    .burst_len(l2), .dout(d2), .dout_valid(v2), .dout_ready(dout_ready), .transfer_done(t2), .overflow(o2));

  assign burst_req = sel ? r2 : r1;
  assign burst_len = sel ? l2 : l1;
  assign dout = sel ? d2 : d1;
  assign dout_valid = sel ? v2 : v1;
  assign transfer_done = sel ? t2 : t1;
  assign overflow = sel ? o2 : o1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (prev_hold) chk("hold_stable", {15'd0, dout_valid, dout}, {15'd0, 1'b1, prev_dout});
    if (burst_req && !prev_req && got.size() > 0) chk("req_after_accept", cyc - last_acc, 1);
    if (burst_req && !prev_req) req_n++;
    if (lat_arm && dout_valid) begin
      chk("ack_to_valid", cyc - ack_cyc, 3);
      lat_arm = 1'b0;
    end
    if (burst_req && burst_ack && !reset) begin
      lens.push_back(burst_len);
      ack_cyc = cyc;
      lat_arm = 1'b1;
    end
    if (dout_valid && dout_ready && !reset) begin
      if (got.size() > 0 && last_acc == cyc - 1) contig++;
      got.push_back(dout);
      last_acc = cyc;
    end
    if (transfer_done) begin
      td_n++;
      td_cyc = cyc;
    end
    prev_hold = dout_valid && !dout_ready && !reset;
    prev_dout = dout;
    prev_req = burst_req;
  end

  task automatic clear_log();
    got.delete();
    lens.delete();
    td_n = 0;
    req_n = 0;
    contig = 0;
    lat_arm = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable_2 = 1'b0;
    burst_ack = 1'b0;
    dout_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic capture(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      enable_2 = 1'b1;
      din = 16'(base + i);
      tick();
    end
    enable_2 = 1'b0;
    din = 16'd0;
  endtask

  task automatic drain(input bit rnd, input int stop_at);
    int c;
    c = 0;
    while (c < 3000 && td_n == 0 && !(stop_at > 0 && got.size() >= stop_at)) begin
      burst_ack = burst_req;
      dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      c++;
    end
    burst_ack = 1'b0;
    dout_ready = 1'b0;
    chk("drain_in_time", 32'(c < 3000), 1);
  endtask

  task automatic chk_seq(input string tag, input int base, input int n);
    chk({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++) chk(tag, {16'd0, got[i]}, 32'(base + i));
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; last_acc = 0; td_cyc = 0; ack_cyc = 0;
    prev_hold = 1'b0; prev_req = 1'b0; sel = 1'b0; start_signal = 1'b0; din = 16'd0;
    do_reset();
    chk("rst_req", burst_req, 0);
    chk("rst_len", burst_len, 0);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_done", transfer_done, 0);
    chk("rst_ovf", overflow, 0);
    // 20-word capture, ready held high
    capture(20, 0);
    tick();
    chk("t1_req", burst_req, 1);
    chk("t1_len", burst_len, 8);
    chk("t1_valid_idle", dout_valid, 0);
    drain(1'b0, 0);
    chk("t1_nbursts", lens.size(), 3);
    chk("t1_len0", lens[0], 8);
    chk("t1_len1", lens[1], 8);
    chk("t1_len2", lens[2], 4);
    chk_seq("t1_data", 0, 20);
    chk("t1_contig", contig, 17);
    chk("t1_done_time", td_cyc, last_acc + 1);
    tick();
    chk("t1_done_once", td_n, 1);
    chk("t1_done_low", transfer_done, 0);
    chk("t1_ovf", overflow, 0);
    // exact multiple of burst size: no trailing burst
    do_reset();
    capture(16, 100);
    drain(1'b0, 0);
    repeat (3) tick();
    chk("t2_nbursts", lens.size(), 2);
    chk("t2_len1", lens[1], 8);
    chk("t2_reqs", req_n, 2);
    chk_seq("t2_data", 100, 16);
    chk("t2_contig", contig, 14);
    chk("t2_done_time", td_cyc, last_acc + 1);
    chk("t2_done_once", td_n, 1);
    // random consumer backpressure
    do_reset();
    capture(20, 500);
    drain(1'b1, 0);
    chk_seq("t3_data", 500, 20);
    chk("t3_done_time", td_cyc, last_acc + 1);
    chk("t3_done_once", td_n, 1);
    // truncation against a 16-word RAM limit
    sel = 1'b1;
    do_reset();
    capture(20, 0);
    chk("t4_ovf_set", overflow, 1);
    drain(1'b0, 0);
    chk("t4_nbursts", lens.size(), 2);
    chk("t4_len0", lens[0], 8);
    chk("t4_len1", lens[1], 8);
    chk_seq("t4_data", 0, 16);
    repeat (3) tick();
    chk("t4_ovf_held", overflow, 1);
    do_reset();
    chk("t4_ovf_cleared", overflow, 0);
    sel = 1'b0;
    // start_signal high blocks capture
    do_reset();
    start_signal = 1'b1;
    capture(5, 50);
    repeat (5) tick();
    chk("t5_blocked_req", req_n, 0);
    chk("t5_blocked_valid", dout_valid, 0);
    start_signal = 1'b0;
    capture(3, 60);
    drain(1'b0, 0);
    chk("t5_nbursts", lens.size(), 1);
    chk("t5_len", lens[0], 3);
    chk_seq("t5_data", 60, 3);
    // reset mid-burst aborts without transfer_done
    do_reset();
    capture(20, 300);
    drain(1'b0, 11);
    chk("t6_words_before_abort", got.size(), 11);
    reset = 1'b1;
    tick();
    chk("t6_req_abort", burst_req, 0);
    chk("t6_valid_abort", dout_valid, 0);
    chk("t6_done_abort", transfer_done, 0);
    reset = 1'b0;
    repeat (5) tick();
    chk("t6_no_done", td_n, 0);
    clear_log();
    capture(4, 400);
    drain(1'b0, 0);
    chk("t6_nbursts", lens.size(), 1);
    chk("t6_len", lens[0], 4);
    chk_seq("t6_data", 400, 4);
    chk("t6_done_once", td_n, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/capture_burst_transfer.md
# capture_burst_transfer

Capture-and-unload stage directly downstream of the clock-domain control block. While the control block's delayed enable (`enable_2`) is high, it writes one input sample per cycle into an internal RAM. When capture ends, it streams the stored words out in request/acknowledge-gated bursts of `burst_index` words. After the last word it pulses `transfer_done`, which the control block uses to issue `reset` and start the next capture cycle.

## Interface
- `address_width`, 14, RAM address width; `wr_addr`/`rd_addr` width.
- `max_ram_address`, 16384, RAM depth in words, ≤ 2^address_width.
- `burst_index`, 8, words per full burst, ≥ 1.
- `data_width`, 16, sample width.

- `variable_clk_2` in 1: sole clock; all logic on posedge.
- `reset` in 1: synchronous, active-high. Clock is `variable_clk_2`.
- `start_signal` in 1: active-low arm from the control block; while high, block holds IDLE.
- `enable_2` in 1: capture qualifier; a sample is written in every cycle it is high.
- `din` in `data_width`: sample written when `enable_2`=1.
- `burst_req` out 1: request to the consumer for one burst.
- `burst_ack` in 1: consumer grant, sampled only while `burst_req`=1.
- `burst_len` out $clog2(`burst_index`+1): word count of the pending burst; valid with `burst_req`.
- `dout` out `data_width`: output word.
- `dout_valid` out 1: `dout` valid.
- `dout_ready` in 1: consumer accepts `dout` when `dout_valid` && `dout_ready`.
- `transfer_done` out 1: one-cycle pulse after the last word is accepted.
- `overflow` out 1: sticky; set when capture was truncated at `max_ram_address`.

## Operation
- Reset values: `burst_req`=0, `burst_len`=0, `dout`=0, `dout_valid`=0, `transfer_done`=0, `overflow`=0, `wr_addr`=0, `rd_addr`=0, state IDLE.
- IDLE:
  - If `start_signal`=0 and `enable_2`=1, write `din` to RAM[0], set `wr_addr`=1 and go to CAPTURE.
  - Otherwise stay in IDLE.
- CAPTURE:
  - Each cycle with `enable_2`=1: if `wr_addr` < `max_ram_address`, write RAM[`wr_addr`] and increment `wr_addr`.
  - If `wr_addr` = `max_ram_address`, drop the sample and set `overflow`.
  - The first cycle with `enable_2`=0 latches total = `wr_addr` and sets remaining = total. Next state is REQ.
- REQ:
  - `burst_req`=1 and `burst_len` = min(`burst_index`, remaining).
  - On `burst_ack`=1: load the burst counter with `burst_len`, deassert `burst_req` next cycle and go to BURST.
- BURST:
  - Read RAM sequentially from `rd_addr`, which persists across bursts. RAM read is synchronous, one-cycle latency.
  - A 2-entry skid buffer sustains one word per cycle while `dout_ready` is held high.
  - `dout` and `dout` order match capture order.
  - `dout` and `dout_valid` hold stable until accepted.
  - After `burst_len` accepts: go to DONE if remaining = 0, else return to REQ.
- DONE: `transfer_done`=1 for exactly one cycle, then IDLE. `wr_addr` and `rd_addr` are cleared; `overflow` is retained.
- `enable_2` is ignored in REQ, BURST and DONE; no RAM writes occur in those states.
- `burst_ack` outside REQ is ignored.
- `start_signal` returning high mid-operation does not abort; it only blocks leaving IDLE.
- Reset in any state aborts immediately: outputs return to reset values next cycle and no `transfer_done` is issued. Reset clears `overflow`.
- Bursts are never zero-length. A total that is an exact multiple of `burst_index` yields no trailing burst.

## Timing
- Capture latency: sample present with `enable_2` at edge n is in RAM at edge n.
- `enable_2` low at edge n → `burst_req`=1 from edge n+1.
- `burst_ack` sampled at edge m → first `dout_valid`=1 at edge m+2.
- With `dout_ready` held high, burst words are accepted on consecutive cycles, with no bubbles within a burst.
- Last accept at edge k → `transfer_done`=1 during cycle k+1 only.
- A new `burst_req` after a non-final burst asserts the cycle after the final accept.
- Control block reset following `transfer_done` arrives while this block is in IDLE, so it is harmless.

## Test plan
- `burst_index`=8: 20 cycles of `enable_2` with ramp `din` 0..19, `burst_ack` one cycle after each req, `dout_ready`=1. Expect `burst_len` 8, 8, 4, `dout` 0..19 in order, and one `transfer_done` pulse one cycle after word 19.
- 16-word capture → exactly two bursts of 8 and no third `burst_req`; `transfer_done` follows word 15.
- 20-word capture with random `dout_ready` (~50%). Expect identical 0..19 sequence, `dout` stable whenever `dout_valid`&&!`dout_ready`, and no lost or duplicated words.
- `max_ram_address`=16, `enable_2` high 20 cycles. Expect 16 words output (0..15), `overflow`=1 held until reset, and bursts 8, 8.
- `start_signal`=1 with `enable_2` pulsed 5 cycles → no `burst_req`, no writes. Then `start_signal`=0 with a 3-cycle capture → one burst, `burst_len`=3.
- Reset asserted after 3 words of the second burst of a 20-word capture. Next cycle: `burst_req`/`dout_valid`=0, no `transfer_done`. A fresh 4-word capture then outputs only the new data from address 0.
